// File: rtl/jedro_1_lsu.sv
// jedro_1_lsu - load-store unit of the jedro_1 core.
//
// Accepts one load/store command at a time from the decoder, drives a
// single-port synchronous data RAM (one-cycle read latency), aligns and
// sign/zero-extends load data and hands it to the register file write port.
// Misaligned or illegal-size accesses are rejected without touching memory
// and flagged with a one-cycle misaligned_o pulse.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid_i / ready_o   command handshake (ready_o high only in IDLE)
//   ctrl_i              [3]=store, [2]=unsigned load, [1:0]=size
//   regdest_i           load destination register
//   addr_i, wdata_i     effective byte address, store data (low bits)
//   mem_*_o             RAM strobe, byte enables, word address, store data
//   mem_rdata_i         RAM read word, valid the cycle after the access
//   rf_wb_o/addr/data   register file write port
//   misaligned_o        one-cycle error pulse
module jedro_1_lsu #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [3:0]                ctrl_i,
    input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
    input  logic [DATA_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      mem_en_o,
    output logic [3:0]                mem_we_o,
    output logic [DATA_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic                      rf_wb_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0]     rf_data_o,
    output logic                      misaligned_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        WB
    } state_t;

    state_t                    state;
    logic [3:0]                ctrl_q;
    logic [REG_ADDR_WIDTH-1:0] regdest_q;
    logic [1:0]                off_q;
    logic                      err_q;

    logic                      misaligned;
    logic [3:0]                st_we;
    logic [DATA_WIDTH-1:0]     st_wdata;
    logic [7:0]                byte_sel;
    logic [15:0]               half_sel;
    logic [DATA_WIDTH-1:0]     load_data;

    assign ready_o = (state == IDLE);

    // Alignment check on the incoming command
    always_comb begin
        misaligned = 1'b0;
        case (ctrl_i[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_i[0];
            2'b10:   misaligned = |addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Store lane replication and byte enables
    always_comb begin
        st_we    = 4'b1111;
        st_wdata = wdata_i;
        case (ctrl_i[1:0])
            2'b00: begin
                st_we    = 4'b0001 << addr_i[1:0];
                st_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                st_we    = 4'b0011 << addr_i[1:0];
                st_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                st_we    = 4'b1111;
                st_wdata = wdata_i;
            end
        endcase
    end

    // Load lane selection using the latched byte offset
    always_comb begin
        byte_sel  = mem_rdata_i[7:0];
        case (off_q)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel  = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_data = mem_rdata_i;
        case (ctrl_q[1:0])
            2'b00:   load_data = {{24{~ctrl_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~ctrl_q[2] & half_sel[15]}}, half_sel};
            default: load_data = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            ctrl_q       <= '0;
            regdest_q    <= '0;
            off_q        <= '0;
            err_q        <= 1'b0;
            mem_en_o     <= 1'b0;
            mem_we_o     <= '0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            rf_wb_o      <= 1'b0;
            rf_addr_o    <= '0;
            rf_data_o    <= '0;
            misaligned_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        ctrl_q    <= ctrl_i;
                        regdest_q <= regdest_i;
                        off_q     <= addr_i[1:0];
                        err_q     <= misaligned;
                        state     <= ACCESS;
                        if (misaligned) begin
                            misaligned_o <= 1'b1;
                        end else begin
                            mem_en_o    <= 1'b1;
                            mem_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                            mem_we_o    <= ctrl_i[3] ? st_we : 4'b0000;
                            mem_wdata_o <= ctrl_i[3] ? st_wdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    mem_en_o     <= 1'b0;
                    mem_we_o     <= '0;
                    mem_addr_o   <= '0;
                    mem_wdata_o  <= '0;
                    misaligned_o <= 1'b0;
                    state        <= (err_q || ctrl_q[3]) ? IDLE : WAIT;
                end
                WAIT: begin
                    // x0 is hardwired zero: read still happens, write-back suppressed
                    rf_wb_o   <= (regdest_q != '0);
                    rf_addr_o <= regdest_q;
                    rf_data_o <= load_data;
                    state     <= WB;
                end
                default: begin
                    rf_wb_o   <= 1'b0;
                    rf_addr_o <= '0;
                    rf_data_o <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Scoreboard bench for jedro_1_lsu: stimulus pushes expected memory,
// error and write-back events; a negedge monitor pops and compares.
module tb_jedro_1_lsu;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ctrl_i;
    logic [4:0]  regdest_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        rf_wb_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        misaligned_o;

    logic [31:0] ram_word;

    typedef struct packed {
        logic [1:0]  kind;   // 0 mem access, 1 misaligned, 2 write-back
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
    } ev_t;

    ev_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    jedro_1_lsu #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .ctrl_i      (ctrl_i),
        .regdest_i   (regdest_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .rf_wb_o     (rf_wb_o),
        .rf_addr_o   (rf_addr_o),
        .rf_data_o   (rf_data_o),
        .misaligned_o(misaligned_o)
    );

    // Synchronous RAM read port: returns ram_word the cycle after a read strobe
    initial mem_rdata_i = '0;
    always @(posedge clk) begin
        if (mem_en_o && mem_we_o == 4'b0000)
            mem_rdata_i <= ram_word;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic check_ev(input string nm, input ev_t act);
        ev_t exp;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected event kind=%0d we=%b addr=%h data=%h rd=%0d, want none",
                     nm, act.kind, act.we, act.addr, act.data, act.rd);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                n_bad++;
                $display("FAIL %s: got kind=%0d we=%b addr=%h data=%h rd=%0d, want kind=%0d we=%b addr=%h data=%h rd=%0d",
                         nm, act.kind, act.we, act.addr, act.data, act.rd,
                         exp.kind, exp.we, exp.addr, exp.data, exp.rd);
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mem_en_o)
            check_ev("mem_access", '{kind: 2'd0, we: mem_we_o, addr: mem_addr_o, data: mem_wdata_o, rd: 5'd0});
        if (misaligned_o)
            check_ev("misaligned", '{kind: 2'd1, we: {3'b000, mem_en_o}, addr: 32'd0, data: 32'd0, rd: 5'd0});
        if (rf_wb_o)
            check_ev("writeback", '{kind: 2'd2, we: 4'd0, addr: 32'd0, data: rf_data_o, rd: rf_addr_o});
    end

    task automatic push_mem(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
        sb.push_back('{kind: 2'd0, we: we, addr: addr, data: data, rd: 5'd0});
    endtask

    task automatic push_err();
        sb.push_back('{kind: 2'd1, we: 4'd0, addr: 32'd0, data: 32'd0, rd: 5'd0});
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
        sb.push_back('{kind: 2'd2, we: 4'd0, addr: 32'd0, data: data, rd: rd});
    endtask

    // Issue one command; lat is the cycle offset at which ready_o returns high
    task automatic issue(input string nm, input logic [3:0] ctrl, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] wdata, input int lat);
        int n = 0;
        @(negedge clk);
        while (!ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_ready_k0"}, 64'(ready_o), 64'd1);
        ctrl_i    = ctrl;
        regdest_i = rd;
        addr_i    = addr;
        wdata_i   = wdata;
        valid_i   = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        check({nm, "_ready_k1"}, 64'(ready_o), 64'd0);
        for (int i = 2; i <= lat; i++) begin
            @(posedge clk);
            #1 check({nm, "_ready_k", $sformatf("%0d", i)}, 64'(ready_o), (i == lat) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        rst_i     = 1'b1;
        valid_i   = 1'b0;
        ctrl_i    = '0;
        regdest_i = '0;
        addr_i    = '0;
        wdata_i   = '0;
        ram_word  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, rf_wb_o,
                                    rf_addr_o, rf_data_o, misaligned_o} != '0), 64'd0);
        check("reset_ready", 64'(ready_o), 64'd1);
        @(negedge clk);
        rst_i = 1'b0;

        // Stores
        push_mem(4'b1111, 32'h0000_0100, 32'hDEAD_BEEF);
        issue("sw", 4'b1010, 5'd0, 32'h0000_0100, 32'hDEAD_BEEF, 2);
        push_mem(4'b1000, 32'h0000_0100, 32'h5A5A_5A5A);
        issue("sb", 4'b1000, 5'd0, 32'h0000_0103, 32'h1234_565A, 2);
        push_mem(4'b1100, 32'h0000_0100, 32'hBEEF_BEEF);
        issue("sh", 4'b1001, 5'd0, 32'h0000_0102, 32'hAAAA_BEEF, 2);

        // Loads
        ram_word = 32'h8001_1234;
        push_mem(4'b0000, 32'h0000_0200, 32'h0);
        push_wb(5'd7, 32'hFFFF_8001);
        issue("lh", 4'b0001, 5'd7, 32'h0000_0202, 32'h0, 4);
        push_mem(4'b0000, 32'h0000_0200, 32'h0);
        push_wb(5'd7, 32'h0000_8001);
        issue("lhu", 4'b0101, 5'd7, 32'h0000_0202, 32'h0, 4);

        ram_word = 32'h0000_F000;
        push_mem(4'b0000, 32'h0000_0300, 32'h0);
        issue("lbu_x0", 4'b0100, 5'd0, 32'h0000_0301, 32'h0, 4);
        push_mem(4'b0000, 32'h0000_0300, 32'h0);
        push_wb(5'd3, 32'hFFFF_FFF0);
        issue("lb", 4'b0000, 5'd3, 32'h0000_0301, 32'h0, 4);

        ram_word = 32'h7F00_0000;
        push_mem(4'b0000, 32'h0000_0200, 32'h0);
        push_wb(5'd9, 32'h0000_007F);
        issue("lb_pos", 4'b0000, 5'd9, 32'h0000_0203, 32'h0, 4);

        ram_word = 32'h1234_5678;
        push_mem(4'b0000, 32'h0000_0404, 32'h0);
        push_wb(5'd5, 32'h1234_5678);
        issue("lw", 4'b0010, 5'd5, 32'h0000_0404, 32'h0, 4);

        // Misaligned / illegal
        push_err();
        issue("lw_mis", 4'b0010, 5'd4, 32'h0000_0402, 32'h0, 2);
        push_err();
        issue("sh_mis", 4'b1001, 5'd0, 32'h0000_0401, 32'hFFFF_FFFF, 2);
        push_err();
        issue("size11", 4'b0011, 5'd6, 32'h0000_0500, 32'h0, 2);

        // Reset during WAIT of a load
        ram_word = 32'hCAFE_F00D;
        push_mem(4'b0000, 32'h0000_0408, 32'h0);
        @(negedge clk);
        ctrl_i    = 4'b0010;
        regdest_i = 5'd8;
        addr_i    = 32'h0000_0408;
        valid_i   = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("midreset_outputs", 64'({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, rf_wb_o,
                                       rf_addr_o, rf_data_o, misaligned_o} != '0), 64'd0);
        check("midreset_ready", 64'(ready_o), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (3) @(posedge clk);

        push_mem(4'b1111, 32'h0000_0600, 32'h0BAD_F00D);
        issue("sw_after_rst", 4'b1010, 5'd0, 32'h0000_0600, 32'h0BAD_F00D, 2);

        repeat (6) @(posedge clk);
        #1 check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jedro_1_lsu.md
# jedro_1_lsu

Load-store unit of the jedro_1 core, sitting downstream of the decoder alongside the ALU. It accepts one load/store command at a time: control, destination register, effective address and store data. It drives a single-port synchronous data RAM with one-cycle read latency, aligns and extends load data, and returns it to the register file write port. Misaligned or illegal-size accesses are rejected without touching memory and flagged to the core.

## Interface
- `DATA_WIDTH`, 32: data and address width; only 32 is supported.
- `REG_ADDR_WIDTH`, 5: register file address width.
- `clk_i` in 1: core clock; all state updates on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `valid_i` in 1: command valid from decoder.
- `ready_o` out 1: unit can accept a command; high only in IDLE.
- `ctrl_i` in 4: bit3 = store(1)/load(0); bit2 = unsigned load; bits1:0 = size (00 byte, 01 half, 10 word, 11 illegal).
- `regdest_i` in REG_ADDR_WIDTH: load destination register.
- `addr_i` in DATA_WIDTH: effective byte address.
- `wdata_i` in DATA_WIDTH: store data, with the value in the low bits.
- `mem_en_o` out 1: RAM access strobe.
- `mem_we_o` out 4: byte write enables; all zero for reads.
- `mem_addr_o` out DATA_WIDTH: word address, with bits 1:0 forced to 0.
- `mem_wdata_o` out DATA_WIDTH: lane-replicated store data.
- `mem_rdata_i` in DATA_WIDTH: RAM read word, valid the cycle after the access cycle.
- `rf_wb_o` out 1: register file write enable.
- `rf_addr_o` out REG_ADDR_WIDTH: register file write address.
- `rf_data_o` out DATA_WIDTH: extended load result.
- `misaligned_o` out 1: one-cycle error pulse.

## Operation
- FSM states: IDLE, ACCESS, WAIT, WB.
- A command is accepted when `valid_i & ready_o`. On acceptance, `ctrl_i`, `regdest_i` and `addr_i[1:0]` are latched.
- Misalignment is any of: half access with `addr[0]=1`; word access with `addr[1:0]!=0`; size 11.
- Transition on an accepted misaligned command: IDLE -> ACCESS with `mem_en_o=0` and `misaligned_o=1` for that cycle only, then -> IDLE. No memory access, no write-back.
- Transition on an accepted valid store: IDLE -> ACCESS -> IDLE.
- Transition on an accepted valid load: IDLE -> ACCESS -> WAIT -> WB -> IDLE.
- Store byte enables:
  - SB: `mem_we_o = 4'b0001 << addr[1:0]`, `mem_wdata_o = {4{wdata[7:0]}}`.
  - SH: `mem_we_o = 4'b0011 << addr[1:0]`, `mem_wdata_o = {2{wdata[15:0]}}`.
  - SW: `mem_we_o = 4'b1111`, `mem_wdata_o = wdata_i`.
- Load extraction: select the byte or half of `mem_rdata_i` using the latched `addr[1:0]`. Sign-extend if bit2 is 0, zero-extend if bit2 is 1. Word loads pass through unchanged.
- A load to x0 performs the memory read, but `rf_wb_o` stays 0.
- `valid_i` is ignored whenever the state is not IDLE.

## Timing
- All memory and register file outputs are registered.
- Reset values: state IDLE, so `ready_o=1`. All other outputs are 0: `mem_en_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `rf_wb_o`, `rf_addr_o`, `rf_data_o`, `misaligned_o`.
- Accept at edge k. During cycle k+1 (ACCESS), `mem_en_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are valid for exactly one cycle.
- Store: `ready_o` returns high in cycle k+2, giving a throughput of 1 store per 2 cycles.
- Load:
  - `mem_rdata_i` is sampled in cycle k+2 (WAIT).
  - `rf_wb_o`, `rf_addr_o` and `rf_data_o` are valid in cycle k+3 (WB), with `rf_wb_o` high for exactly one cycle.
  - `ready_o` is high again in cycle k+4, giving a throughput of 1 load per 4 cycles.
- Misaligned command: `misaligned_o` is high in cycle k+1 and `ready_o` is high in cycle k+2.
- Reset asserted mid-operation immediately forces IDLE and zeroes all outputs. The pending access is dropped: no write-back, and no `mem_en_o` after reset deasserts.
- `ready_o` is a decode of the state only; there is no combinational path from any input.

## Test plan
- SW of `0xDEADBEEF` at `0x100` -> in cycle k+1: `mem_en_o=1`, `mem_we_o=1111`, `mem_addr_o=0x100`, `mem_wdata_o=0xDEADBEEF`. `ready_o=0` in k+1 and `ready_o=1` in k+2.
- SB of `0x5A` at `0x103` -> `mem_we_o=1000`, `mem_addr_o=0x100`, `mem_wdata_o=0x5A5A5A5A`.
- LH to x7 at `0x202`, with RAM word `0x8001_1234` -> in cycle k+3: `rf_wb_o=1`, `rf_addr_o=7`, `rf_data_o=0xFFFF8001`. LHU of the same access -> `rf_data_o=0x00008001`.
- LBU to x0 at `0x301`, with RAM word `0x0000_F000` -> `mem_en_o` pulses once and `rf_wb_o` stays 0. LB to x3 of the same access -> `rf_data_o=0xFFFFFFF0`.
- LW at `0x402` -> `misaligned_o=1` in cycle k+1 only, `mem_en_o=0` throughout, no `rf_wb_o`, and `ready_o=1` in k+2. Same response for SH at `0x401` and for `ctrl_i` size 11.
- Assert `rst_i` asynchronously in cycle k+2 of an LW -> all outputs are 0 immediately and `rf_wb_o` never asserts. After release, a new SW is accepted normally.
